// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI main-side transfer engine.
package spi_pkg;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Divider value held in the latch while no transfer has been accepted.
    localparam int DEFAULT_DIV = 1;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, sclk toggle, leading/trailing edge strobes.
// Strobes are combinational and coincide with the pclk edge on which sclk toggles.
module spi_sclk_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             load,
    input  logic             load_cpol,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             sclk,
    output logic             lead,
    output logic             trail,
    output logic             last
);

    localparam int EDGES = 2 * DATA_WIDTH;
    localparam int EW    = $clog2(EDGES);

    logic [DIV_W-1:0] hp_cnt;
    logic [EW-1:0]    edge_cnt;
    logic             tick;

    // edge_cnt holds the number of edges already produced, so the next edge is odd (leading) when it is even.
    assign tick  = run && (hp_cnt == div);
    assign lead  = tick && !edge_cnt[0];
    assign trail = tick && edge_cnt[0];
    assign last  = tick && (edge_cnt == EW'(EDGES - 1));

    // Half-period counting and sclk toggling; load snaps sclk to the idle level of the new frame.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            hp_cnt   <= '0;
            edge_cnt <= '0;
            sclk     <= 1'b0;
        end else if (load) begin
            hp_cnt   <= '0;
            edge_cnt <= '0;
            sclk     <= load_cpol;
        end else if (tick) begin
            hp_cnt   <= '0;
            sclk     <= ~sclk;
            edge_cnt <= last ? '0 : edge_cnt + EW'(1);
        end else if (run) begin
            hp_cnt   <= hp_cnt + DIV_W'(1);
        end else begin
            hp_cnt   <= '0;
        end
    end

endmodule

// File: rtl/spi_main_xfer.sv
// SPI main-side transfer engine: takes bytes by valid/ready, drives sclk/ss_n/mosi,
// samples miso and emits each received byte with a one-cycle rx_valid pulse.
// Bytes offered in the final HOLD cycle are burst with ss_n kept low.
module spi_main_xfer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    state_t                state;
    logic [DIV_W-1:0]      div_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [DIV_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  accept;
    logic                  lead;
    logic                  trail;
    logic                  last;
    logic                  sample;

    assign tx_ready = (state == IDLE) || ((state == HOLD) && (cnt == div_q));
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);
    assign sample   = cpha_q ? trail : lead;

    // Mode is only latched from IDLE; a burst continuation keeps the current cpol.
    spi_sclk_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_W      (DIV_W)
    ) u_sclk (
        .pclk      (pclk),
        .presetn   (presetn),
        .load      (accept),
        .load_cpol ((state == IDLE) ? cpol : cpol_q),
        .run       (state == SHIFT),
        .div       (div_q),
        .sclk      (sclk),
        .lead      (lead),
        .trail     (trail),
        .last      (last)
    );

    // Transfer FSM with the shift registers and all registered outputs.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state    <= IDLE;
            div_q    <= DIV_W'(DEFAULT_DIV);
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            cnt      <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_q  <= clk_div;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        tx_sr  <= tx_data;
                        // CPHA=0 must present the MSB a half-period ahead of edge 1.
                        mosi   <= cpha ? 1'b0 : tx_data[DATA_WIDTH-1];
                        ss_n   <= 1'b0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sample)
                        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                    if (cpha_q && lead) begin
                        mosi  <= tx_sr[DATA_WIDTH-1];
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (!cpha_q && trail && !last) begin
                        mosi  <= tx_sr[DATA_WIDTH-2];
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (last) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                    end
                    if (cnt == div_q) begin
                        cnt <= '0;
                        if (tx_valid) begin
                            tx_sr <= tx_data;
                            if (!cpha_q)
                                mosi <= tx_data[DATA_WIDTH-1];
                            state <= SHIFT;
                        end else begin
                            ss_n  <= 1'b1;
                            mosi  <= 1'b0;
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == div_q) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main_xfer.sv
// Directed bench for spi_main_xfer: table of single-frame vectors plus hand sequences
// for burst, mid-burst config change, reset abort and tx_valid outside tx_ready.
module tb_spi_main_xfer;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [7:0] clk_div;
    logic       cpol, cpha;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, sclk, ss_n, mosi, miso;

    spi_main_xfer #(.DATA_WIDTH(8), .DIV_W(8)) dut (
        .pclk(pclk), .presetn(presetn), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 pclk = ~pclk;

    // Mode-0 subordinate: returns slv_byte MSB-first, advancing on each falling sclk.
    logic [7:0] slv_byte = 8'h3C;
    logic [2:0] slv_idx  = 3'd0;
    logic       loop;
    always @(negedge sclk or posedge ss_n) begin
        if (ss_n) slv_idx = 3'd0;
        else      slv_idx = slv_idx + 3'd1;
    end
    assign miso = loop ? mosi : slv_byte[3'd7 - slv_idx];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Per-run observations.
    int         edges, gap_cyc, ss_rise;
    logic [31:0] lead_bits, trail_bits;
    int         rx_k[$];
    logic [7:0] rx_b[$];
    int         acc_k[$];
    logic [7:0] q[$];

    // Offers q[] (first byte immediately, later bytes from cycle valid_from), observes until idle.
    // k counts negedges after the pclk edge that accepted the first byte.
    task automatic run(input int max_k, input int valid_from, input bit chg,
                       input logic [7:0] chg_div, input logic chg_cpha);
        int   k, qi;
        logic acc, ps, pss;
        bit   timeout;
        edges = 0; gap_cyc = 0; ss_rise = 0; lead_bits = 0; trail_bits = 0;
        rx_k.delete(); rx_b.delete(); acc_k.delete();
        k = -1; qi = 0; timeout = 1'b1;
        tx_data = q[0]; tx_valid = 1'b1;
        ps = sclk; pss = ss_n;
        while (k < max_k) begin
            acc = tx_valid && tx_ready;
            @(negedge pclk); k++;
            if (acc) begin acc_k.push_back(k); qi++; end
            if (k > 0 && sclk !== ps) begin
                edges++;
                if (edges % 2 == 1) lead_bits  = {lead_bits[30:0], mosi};
                else                trail_bits = {trail_bits[30:0], mosi};
            end
            ps = sclk;
            if (rx_valid) begin rx_k.push_back(k); rx_b.push_back(rx_data); end
            if (busy && ss_n) gap_cyc++;
            if (busy && ss_n && !pss) ss_rise++;
            pss = ss_n;
            if (chg && k == 0) begin clk_div = chg_div; cpha = chg_cpha; end
            tx_valid = (qi < q.size()) && (k >= valid_from);
            if (qi < q.size()) tx_data = q[qi];
            if (qi >= q.size() && !busy) begin timeout = 1'b0; break; end
        end
        tx_valid = 1'b0;
        chk("run_completes", {31'b0, timeout}, 32'd0);
    endtask

    task automatic chk_acc(input string name, input int i, input int exp);
        chk(name, (i < acc_k.size()) ? acc_k[i] : -1, exp);
    endtask
    task automatic chk_rx(input string name, input int i, input int exp_k, input logic [7:0] exp_b);
        chk({name, "_cycle"}, (i < rx_k.size()) ? rx_k[i] : -1, exp_k);
        chk({name, "_data"}, (i < rx_b.size()) ? {24'b0, rx_b[i]} : 32'hFFFF_FFFF, {24'b0, exp_b});
    endtask

    typedef struct {
        logic       cpol, cpha;
        logic [7:0] div;
        logic [7:0] tx;
        logic       loop;
        logic [7:0] exp_rx;
        int         exp_rxk;
    } vec_t;

    vec_t vt[5];
    int   cnt_rv;

    initial begin
        // cpol cpha div  tx   loop  rx   rx cycle = 16*(div+1)+1
        vt[0] = '{1'b0, 1'b0, 8'd1, 8'hA5, 1'b0, 8'h3C, 33};
        vt[1] = '{1'b0, 1'b0, 8'd0, 8'hFF, 1'b0, 8'h3C, 17};
        vt[2] = '{1'b0, 1'b1, 8'd2, 8'h5A, 1'b1, 8'h5A, 49};
        vt[3] = '{1'b1, 1'b1, 8'd0, 8'h81, 1'b1, 8'h81, 17};
        vt[4] = '{1'b1, 1'b0, 8'd0, 8'hC3, 1'b1, 8'hC3, 17};

        presetn = 1'b0; clk_div = 8'd1; cpol = 1'b0; cpha = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; loop = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_sclk", {31'b0, sclk}, 0);
        chk("rst_ss_n", {31'b0, ss_n}, 1);
        chk("rst_mosi", {31'b0, mosi}, 0);
        chk("rst_rx_data", {24'b0, rx_data}, 0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 1);
        presetn = 1'b1;
        @(negedge pclk);

        // Single frames in every mode.
        for (int i = 0; i < 5; i++) begin
            cpol = vt[i].cpol; cpha = vt[i].cpha; clk_div = vt[i].div; loop = vt[i].loop;
            q = '{vt[i].tx};
            run(400, 0, 1'b0, 8'd0, 1'b0);
            chk($sformatf("v%0d_rx_count", i), rx_k.size(), 1);
            chk_rx($sformatf("v%0d_rx", i), 0, vt[i].exp_rxk, vt[i].exp_rx);
            chk($sformatf("v%0d_lead_mosi", i), {24'b0, lead_bits[7:0]}, {24'b0, vt[i].tx});
            chk($sformatf("v%0d_edges", i), edges, 16);
            chk($sformatf("v%0d_gap_cycles", i), gap_cyc, vt[i].div + 1);
            chk($sformatf("v%0d_idle_sclk", i), {31'b0, sclk}, {31'b0, vt[i].cpol});
            chk($sformatf("v%0d_idle_ss_n", i), {31'b0, ss_n}, 1);
            chk($sformatf("v%0d_idle_mosi", i), {31'b0, mosi}, 0);
        end

        // Burst of three bytes, mode 0, clk_div=1, loopback.
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; loop = 1'b1;
        q = '{8'h12, 8'h34, 8'h56};
        run(400, 0, 1'b0, 8'd0, 1'b0);
        chk_acc("burst_acc1", 1, 34);
        chk_acc("burst_acc2", 2, 68);
        chk_rx("burst_rx0", 0, 33, 8'h12);
        chk_rx("burst_rx1", 1, 67, 8'h34);
        chk_rx("burst_rx2", 2, 101, 8'h56);
        chk("burst_rx_count", rx_k.size(), 3);
        chk("burst_ss_n_rises", ss_rise, 1);
        chk("burst_gap_cycles", gap_cyc, 2);
        chk("burst_lead_mosi", {8'b0, lead_bits[23:0]}, 32'h0012_3456);

        // clk_div 3->0 and cpha 0->1 right after the first accept; second frame keeps div 3, cpha 0.
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd3; loop = 1'b0;
        q = '{8'h12, 8'h34};
        run(600, 0, 1'b1, 8'd0, 1'b1);
        chk_acc("cfg_acc1", 1, 68);
        chk_rx("cfg_rx0", 0, 65, 8'h3C);
        chk_rx("cfg_rx1", 1, 133, 8'h3C);
        chk("cfg_trail_mosi", {24'b0, trail_bits[7:0]}, 32'h68);
        chk("cfg_edges", edges, 32);
        chk("cfg_gap_cycles", gap_cyc, 4);

        // Reset after edge 5 of a mode-0 frame.
        cpha = 1'b0; clk_div = 8'd1; loop = 1'b0;
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        repeat (10) @(negedge pclk);
        chk("prerst_sclk", {31'b0, sclk}, 1);
        chk("prerst_ss_n", {31'b0, ss_n}, 0);
        presetn = 1'b0;
        @(negedge pclk);
        chk("midrst_sclk", {31'b0, sclk}, 0);
        chk("midrst_ss_n", {31'b0, ss_n}, 1);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_mosi", {31'b0, mosi}, 0);
        chk("midrst_rx_data", {24'b0, rx_data}, 0);
        cnt_rv = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx_valid) cnt_rv++;
            if (i == 1) presetn = 1'b1;
            @(negedge pclk);
        end
        chk("midrst_no_rx_valid", cnt_rv, 0);
        q = '{8'hA5};
        run(400, 0, 1'b0, 8'd0, 1'b0);
        chk_rx("postrst_rx", 0, 33, 8'h3C);
        chk("postrst_lead_mosi", {24'b0, lead_bits[7:0]}, 32'hA5);
        chk("postrst_rx_count", rx_k.size(), 1);

        // tx_valid raised mid-SHIFT: taken only on the final HOLD cycle.
        loop = 1'b1; clk_div = 8'd1;
        q = '{8'h5A, 8'hC3};
        run(400, 5, 1'b0, 8'd0, 1'b0);
        chk_acc("shiftv_acc1", 1, 34);
        chk_rx("shiftv_rx0", 0, 33, 8'h5A);
        chk_rx("shiftv_rx1", 1, 67, 8'hC3);

        // tx_valid raised in GAP: taken only once back in IDLE.
        q = '{8'hA5, 8'h3C};
        run(400, 34, 1'b0, 8'd0, 1'b0);
        chk_acc("gapv_acc1", 1, 37);
        chk_rx("gapv_rx0", 0, 33, 8'hA5);
        chk_rx("gapv_rx1", 1, 70, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_main_xfer.md
Name: spi_main_xfer

Overview:
- SPI main-side transfer engine; the controller-end counterpart of the subordinate shift-register block.
- Accepts bytes from the TX FIFO via valid/ready, generates sclk and ss_n, shifts mosi out MSB-first and samples miso.
- Presents each received byte with a one-cycle rx_valid pulse to the RX FIFO.
- Back-to-back bytes are burst with ss_n held low.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame.
- DIV_W, 8, width of the clock-divider input.

Ports:
- pclk  in  1  system clock; all logic on its rising edge.
- presetn  in  1  reset, synchronous, active-low.
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 pclk cycles; latched on accept from IDLE.
- cpol  in  1  SCLK idle level; latched on accept from IDLE.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept from IDLE.
- tx_data  in  DATA_WIDTH  byte to send.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  combinational; accept = tx_valid & tx_ready.
- rx_data  out  DATA_WIDTH  last received byte; held until the next frame completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high whenever state != IDLE.
- sclk  out  1  SPI clock.
- ss_n  out  1  subordinate select, active-low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset values: sclk=cpol_q=0, ss_n=1, mosi=0, rx_data=0, rx_valid=0, busy=0, state=IDLE, all counters 0. Reset mid-transfer aborts on the next pclk edge; no rx_valid is generated.
- States:
  - IDLE: tx_ready=1. On accept: latch tx_data, clk_div, cpol, cpha; ss_n<=0; go to SHIFT.
  - SHIFT: half-period counter hp_cnt counts 0..clk_div_q. When hp_cnt==clk_div_q, sclk toggles, hp_cnt clears and edge_cnt increments. After edge 2*DATA_WIDTH, go to HOLD; rx_valid pulses in the first HOLD cycle.
  - HOLD: ss_n low, sclk at idle, lasts clk_div_q+1 cycles. In its last cycle tx_ready=1. On accept, load the new byte and re-enter SHIFT with ss_n still low; mode and divider are not re-latched. Otherwise go to GAP.
  - GAP: ss_n=1 for clk_div_q+1 cycles, then IDLE. tx_ready=0.
- Edges: odd-numbered edges are leading, even-numbered edges are trailing.
- CPHA=0:
  - mosi = tx_sr MSB from the accept cycle onward, so the MSB is valid one half-period before the first edge.
  - Sample miso on leading edges; shift tx_sr on trailing edges except the last.
- CPHA=1:
  - mosi updates to the next bit on each leading edge, starting with the MSB at edge 1.
  - Sample miso on trailing edges.
- Receive: rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso} at each sample edge; rx_data <= rx_sr result when the frame ends.
- Timing: from accept in IDLE to rx_valid is 2*DATA_WIDTH*(clk_div+1)+1 cycles.
- Boundaries:
  - tx_valid ignored outside tx_ready.
  - clk_div=0 gives sclk = pclk/2.
  - cpol/cpha/clk_div changes mid-burst have no effect.
  - mosi returns to 0 in GAP/IDLE.

Decomposition:
- Package spi_pkg: state enum (IDLE, SHIFT, HOLD, GAP) and a DEFAULT_DIV constant.
- Sub-module spi_sclk_gen (half-period counter, sclk toggle, leading/trailing strobes).
- Shift registers and FSM stay in the top module.

Test Plan:
1. Mode 0, clk_div=1, tx 0xA5, miso driven by a subordinate model returning 0x3C:
   - mosi bits 1,0,1,0,0,1,0,1 at leading edges.
   - rx_valid with rx_data=0x3C at cycle 33 after accept.
   - ss_n high after HOLD+GAP.
2. Mode 3 (cpol=1, cpha=1), clk_div=0, tx 0x81, loopback miso=mosi:
   - sclk idles high.
   - rx_data=0x81, 16 sclk edges total.
3. Burst: tx_valid held with 0x12, 0x34, 0x56:
   - ss_n stays low across all three frames.
   - Three rx_valid pulses.
   - Single GAP only after 0x56.
4. Change clk_div from 3 to 0 and cpha mid-burst:
   - Second frame still uses half-period 4 and the original cpha.
5. presetn low mid-SHIFT (after edge 5):
   - Next cycle sclk=0, ss_n=1, busy=0, no rx_valid.
   - Next accept runs a clean frame.
6. tx_valid asserted during SHIFT and GAP:
   - tx_ready=0, no accept.
   - Accepted only once back in IDLE or on the final HOLD cycle.
